// File: rtl/u_dly_coarse_prog_pkg.sv
// Shared defaults and helpers for the programmable coarse delay line.
// Provides the default data width, depth and reset select for the delay line.
// Also provides the helper that sizes the select field for a given depth.
package u_dly_coarse_prog_pkg;

  localparam int DLY_DW_DEF      = 1;
  localparam int DLY_DEPTH_DEF   = 8;
  localparam int DLY_DEF_SEL_DEF = 0;

  // Select must encode 0..depth inclusive.
  function automatic int dly_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/u_dly_tap_mux.sv
// One-level (DEPTH+1):1 tap selector for the coarse delay line.
// Ports: i_sel picks the source (0 = i_in, k = tap k), i_in is the live sample,
//        i_taps holds taps 1..DEPTH packed LSB-first, and o_out is the selected sample.
module u_dly_tap_mux #(
  parameter int DW    = 1,
  parameter int DEPTH = 8,
  parameter int SW    = 4
) (
  input  logic [SW-1:0]       i_sel,
  input  logic [DW-1:0]       i_in,
  input  logic [DEPTH*DW-1:0] i_taps,
  output logic [DW-1:0]       o_out
);

  // Select 0 is a zero-latency pass of the live input. The select is
  // clamped upstream, so codes above DEPTH do not occur.
  always_comb begin
    o_out = i_in;
    for (int k = 1; k <= DEPTH; k++) begin
      if (i_sel == SW'(k)) o_out = i_taps[(k-1)*DW +: DW];
    end
  end

endmodule

// File: rtl/u_dly_coarse_prog.sv
// Programmable coarse delay line with a delay of 0..DEPTH enabled clock steps.
// Ports: i_in/i_en shift the samples, i_flush clears the history, i_sel/i_sel_load load the
//        delay, o_out/o_vld carry the delayed sample, and o_sel_cur/o_sel_err report the select.
module u_dly_coarse_prog
  import u_dly_coarse_prog_pkg::*;
#(
  parameter int DW      = DLY_DW_DEF,
  parameter int DEPTH   = DLY_DEPTH_DEF,
  parameter int SW      = dly_sel_w(DEPTH),
  parameter int DEF_SEL = DLY_DEF_SEL_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [DW-1:0] i_in,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic [SW-1:0] i_sel,
  input  logic          i_sel_load,
  output logic [DW-1:0] o_out,
  output logic          o_vld,
  output logic [SW-1:0] o_sel_cur,
  output logic          o_sel_err
);

  localparam logic [SW-1:0] DEP_S = SW'(DEPTH);

  // sr_q[k] is tap k+1: the sample seen k+1 enabled edges ago.
  logic [DW-1:0]       sr_q   [DEPTH];
  logic [DW-1:0]       sr_d   [DEPTH];
  logic [SW-1:0]       fill_q, fill_d;
  logic [SW-1:0]       sel_q,  sel_d;
  logic                err_q,  err_d;
  logic [DEPTH*DW-1:0] taps_flat;

  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    sel_d  = sel_q;
    err_d  = 1'b0;

    // Flush wins over shift. The sample on i_in at a flush edge is dropped.
    if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) sr_d[k] = '0;
      fill_d = '0;
    end else if (i_en) begin
      sr_d[0] = i_in;
      for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
      if (fill_q < DEP_S) fill_d = fill_q + SW'(1);
    end

    // A load is independent of the shift and flush paths, so it never disturbs the history.
    if (i_sel_load) begin
      if (i_sel > DEP_S) begin
        sel_d = DEP_S;
        err_d = 1'b1;
      end else begin
        sel_d = i_sel;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
      fill_q <= '0;
      sel_q  <= SW'(DEF_SEL);
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    taps_flat = '0;
    for (int k = 0; k < DEPTH; k++) taps_flat[k*DW +: DW] = sr_q[k];
  end

  u_dly_tap_mux #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_mux (
    .i_sel  (sel_q),
    .i_in   (i_in),
    .i_taps (taps_flat),
    .o_out  (o_out)
  );

  assign o_vld     = (fill_q >= sel_q);
  assign o_sel_cur = sel_q;
  assign o_sel_err = err_q;

endmodule

// File: tb/tb_u_dly_coarse_prog.sv
module tb_u_dly_coarse_prog;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] in_s;
  logic          en, flush, load;
  logic [SW-1:0] sel;
  logic [DW-1:0] out_s;
  logic          vld;
  logic [SW-1:0] sel_cur;
  logic          sel_err;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: the history is kept newest-first, holding at most DEPTH samples.
  logic [DW-1:0] hist[$];
  int            m_sel;
  bit            m_err;

  always #5 clk = ~clk;

  u_dly_coarse_prog #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .SW      (SW),
    .DEF_SEL (0)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_in       (in_s),
    .i_en       (en),
    .i_flush    (flush),
    .i_sel      (sel),
    .i_sel_load (load),
    .o_out      (out_s),
    .o_vld      (vld),
    .o_sel_cur  (sel_cur),
    .o_sel_err  (sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_sel = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (flush) hist.delete();
    else if (en) begin
      hist.push_front(in_s);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    m_err = 1'b0;
    if (load) begin
      if (int'(sel) > DEPTH) begin
        m_sel = DEPTH;
        m_err = 1'b1;
      end else m_sel = int'(sel);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [DW-1:0] e_out;
    if (m_sel == 0) e_out = in_s;
    else if (hist.size() >= m_sel) e_out = hist[m_sel-1];
    else e_out = '0;
    chk({tag, ".out"}, 32'(out_s), 32'(e_out));
    chk({tag, ".vld"}, 32'(vld), 32'(hist.size() >= m_sel));
    chk({tag, ".sel"}, 32'(sel_cur), 32'(m_sel));
    chk({tag, ".err"}, 32'(sel_err), 32'(m_err));
  endtask

  task automatic cyc(input string tag, input logic e, input logic f, input logic l,
                     input logic [SW-1:0] s, input logic [DW-1:0] d);
    en = e; flush = f; load = l; sel = s; in_s = d;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    rstn = 1'b0; in_s = 4'h5; en = 1'b0; flush = 1'b0; load = 1'b0; sel = '0;
    model_reset();

    // 1: reset state, zero-latency pass-through with DEF_SEL=0
    #3;
    chk("rst.vld", 32'(vld), 32'd1);
    chk("rst.out", 32'(out_s), 32'h5);
    chk("rst.sel", 32'(sel_cur), 32'd0);
    chk("rst.err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    in_s = 4'h9;
    #1;
    chk("pass.out", 32'(out_s), 32'h9);
    cyc("idle", 1'b0, 1'b0, 1'b0, 4'd0, 4'h3);

    // 2: sel=3, shift in A,B,C,D
    cyc("ld3", 1'b0, 1'b0, 1'b1, 4'd3, 4'h0);
    cyc("s2a", 1'b1, 1'b0, 1'b0, 4'd0, 4'hA);
    chk("s2a.vld0", 32'(vld), 32'd0);
    cyc("s2b", 1'b1, 1'b0, 1'b0, 4'd0, 4'hB);
    cyc("s2c", 1'b1, 1'b0, 1'b0, 4'd0, 4'hC);
    chk("s2c.vld1", 32'(vld), 32'd1);
    chk("s2c.outA", 32'(out_s), 32'hA);
    cyc("s2d", 1'b1, 1'b0, 1'b0, 4'd0, 4'hD);
    chk("s2d.outB", 32'(out_s), 32'hB);

    // 3: sel=2 with gated enable (flush first so history is fresh)
    cyc("f_ld2", 1'b0, 1'b1, 1'b1, 4'd2, 4'h0);
    for (int i = 0; i < 8; i++)
      cyc("gate", 1'(i % 2 == 0), 1'b0, 1'b0, 4'd0, 4'($urandom_range(0, 15)));

    // 4: out-of-range load clamps and pulses the error for one cycle
    cyc("ld12", 1'b0, 1'b0, 1'b1, 4'd12, 4'h1);
    chk("ld12.sel8", 32'(sel_cur), 32'd8);
    chk("ld12.err1", 32'(sel_err), 32'd1);
    cyc("ld12n", 1'b0, 1'b0, 1'b0, 4'd0, 4'h2);
    chk("ld12n.err0", 32'(sel_err), 32'd0);

    // 5: full history, sel=5, then flush+load 0 on the same edge
    for (int i = 0; i < 9; i++)
      cyc("fill", 1'b1, 1'b0, 1'(i == 8), 4'd5, 4'($urandom_range(0, 15)));
    cyc("fl0", 1'b1, 1'b1, 1'b1, 4'd0, 4'h7);
    chk("fl0.vld", 32'(vld), 32'd1);
    chk("fl0.out", 32'(out_s), 32'h7);
    cyc("fl_ld5", 1'b0, 1'b0, 1'b1, 4'd5, 4'h6);
    chk("fl_ld5.tap0", 32'(out_s), 32'h0);
    chk("fl_ld5.vld0", 32'(vld), 32'd0);

    // Randomised traffic checked against the model every cycle
    for (int i = 0; i < 400; i++)
      cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));

    // 6: asynchronous reset mid-stream, checked before any clock edge
    cyc("pre_rst", 1'b1, 1'b0, 1'b1, 4'd13, 4'hE);
    #2;
    rstn = 1'b0;
    in_s = 4'hC;
    #1;
    model_reset();
    chk_all("arst");
    @(negedge clk);
    rstn = 1'b1;
    cyc("post_rst", 1'b1, 1'b0, 1'b1, 4'd1, 4'h4);
    cyc("post_rst2", 1'b1, 1'b0, 1'b0, 4'd0, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
